// File: rtl/instr_encoder.sv
// Packs format/register/funct3/immediate requests into RV32I instruction words
// and emits them with sequential imem byte addresses through one registered stage.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_ILOAD  = 3'd0;
  localparam logic [2:0] FMT_IARITH = 3'd1;
  localparam logic [2:0] FMT_S      = 3'd2;
  localparam logic [2:0] FMT_B      = 3'd3;
  localparam logic [2:0] FMT_J      = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  localparam logic signed [31:0] I_MIN = -32'sd2048;
  localparam logic signed [31:0] I_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN = -32'sd4096;
  localparam logic signed [31:0] B_MAX = 32'sd4094;
  localparam logic signed [31:0] J_MIN = -32'sd1048576;
  localparam logic signed [31:0] J_MAX = 32'sd1048574;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [31:0]      out_addr_q,  out_addr_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q,  err_code_d;
  logic [CNT_W-1:0] inst_cnt_q,  inst_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic             accept, consume;
  logic [31:0]      enc_instr;
  logic [1:0]       enc_err;
  logic signed [31:0] imm_s;

  // Handshake: a side transfers on the rising edge where its valid and ready
  // are both high; in_ready opens when the output stage is empty or draining.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;
  assign imm_s    = in_imm;

  always_comb begin
    enc_instr = 32'h0;
    enc_err   = ERR_NONE;
    case (in_fmt)
      FMT_ILOAD, FMT_IARITH: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd,
                     (in_fmt == FMT_ILOAD) ? 7'b0000011 : 7'b0010011};
        if (imm_s < I_MIN || imm_s > I_MAX) enc_err = ERR_RANGE;
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        if (imm_s < I_MIN || imm_s > I_MAX) enc_err = ERR_RANGE;
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], 7'b1100011};
        if (in_imm[0])                           enc_err = ERR_ALIGN;
        else if (imm_s < B_MIN || imm_s > B_MAX) enc_err = ERR_RANGE;
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        if (in_imm[0])                           enc_err = ERR_ALIGN;
        else if (imm_s < J_MIN || imm_s > J_MAX) enc_err = ERR_RANGE;
      end
      default: enc_err = ERR_FMT;
    endcase
  end

  // out_addr_q always holds the address the next emitted instruction will carry,
  // so advancing it on consume also covers the consume-and-accept case.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    inst_cnt_d  = inst_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (consume) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + 32'd4;
      inst_cnt_d  = inst_cnt_q + CNT_ONE;
    end
    if (accept) begin
      if (enc_err == ERR_NONE) begin
        out_valid_d = 1'b1;
        out_instr_d = enc_instr;
      end else begin
        err_valid_d = 1'b1;
        err_code_d  = enc_err;
        err_cnt_d   = err_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_addr_q  <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      inst_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      inst_cnt_q  <= inst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign inst_count = inst_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words/addresses and error codes are
// queued when a request is accepted and compared when the DUT presents its result.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = 3'd0;
  logic [4:0]    in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]    in_funct3 = 3'd0;
  logic [31:0]   in_imm = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr, out_addr;
  logic          err_valid;
  logic [1:0]    err_code;
  logic [CW-1:0] inst_count, err_count;

  instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code),
    .inst_count(inst_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [1:0]  err_q[$];
  logic [31:0] exp_addr = BASE;
  int          exp_inst = 0;
  int          exp_errn = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        toggle_en = 1'b0;
  logic        rand_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built by shifting fields into place; bit 33:32 = error code.
  function automatic logic [33:0] model(input logic [2:0] fmt, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    int signed v;
    logic [31:0] w;
    logic [1:0]  e;
    v = imm;
    w = 32'h0;
    e = 2'd0;
    case (fmt)
      3'd0, 3'd1: begin
        w = ((fmt == 3'd0) ? 32'h03 : 32'h13) | (32'(rd) << 7) | (32'(f3) << 12) |
            (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
        if (v < -2048 || v > 2047) e = 2'd1;
      end
      3'd2: begin
        w = 32'h23 | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) |
            (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
        if (v < -2048 || v > 2047) e = 2'd1;
      end
      3'd3: begin
        w = 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) |
            (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) |
            (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
        if (imm[0]) e = 2'd2;
        else if (v < -4096 || v > 4094) e = 2'd1;
      end
      3'd4: begin
        w = 32'h6F | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 20) & 32'h1) << 31);
        if (imm[0]) e = 2'd2;
        else if (v < -1048576 || v > 1048574) e = 2'd1;
      end
      default: e = 2'd3;
    endcase
    return {e, w};
  endfunction

  // Drives one request; use_exp selects the explicit expected word/code over the model.
  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
      input logic use_exp, input logic [1:0] xe, input logic [31:0] xw);
    logic [33:0] m;
    bit done;
    m = use_exp ? {xe, xw} : model(fmt, rd, rs1, rs2, f3, imm);
    in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (m[33:32] == 2'd0) begin
          exp_q.push_back({m[31:0], exp_addr});
          exp_addr = exp_addr + 32'd4;
        end else begin
          err_q.push_back(m[33:32]);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 1, 0);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && err_q.size() == 0 && !out_valid && !err_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); err_q.delete();
    exp_addr = BASE; exp_inst = 0; exp_errn = 0;
  endtask

  // Scoreboard: pop on every consumed output and on every error pulse.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_instr", 64'(out_instr), 64'(e[63:32]));
        chk("out_addr", 64'(out_addr), 64'(e[31:0]));
        exp_inst++;
      end
    end
    if (!rst && err_valid) begin
      if (err_q.size() == 0) chk("spurious_err", 1, 0);
      else chk("err_code", 64'(err_code), 64'(err_q.pop_front()));
      exp_errn++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (toggle_en) out_ready = ~out_ready;
    else if (rand_en) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_instr", 64'(out_instr), 0);
    chk("rst_out_addr", 64'(out_addr), 64'(BASE));
    chk("rst_err_valid", 64'(err_valid), 0);
    chk("rst_err_code", 64'(err_code), 0);
    chk("rst_inst_count", 64'(inst_count), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;

    // Basic encodings with hand-derived words
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1, 2'd0, 32'hFFF00093);
    send(3'd2, 5'd0, 5'd2, 5'd5, 3'b010, 32'd8, 1, 2'd0, 32'h00512423);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 1, 2'd0, 32'hFE000EE3);
    drain();
    chk("inst_count_t2", 64'(inst_count), 64'(exp_inst));
    chk("inst_count_abs", 64'(inst_count), 3);

    // Backpressure hold
    out_ready = 1'b0;
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1, 2'd0, 32'h001000EF);
    repeat (3) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 0);
      chk("hold_out_valid", 64'(out_valid), 1);
      chk("hold_out_instr", 64'(out_instr), 64'h001000EF);
      chk("hold_out_addr", 64'(out_addr), 64'(BASE + 32'd12));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
    chk("inst_count_t3", 64'(inst_count), 4);

    // Rejections, including priority cases
    send(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 32'd2048, 1, 2'd1, 32'h0);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 1, 2'd2, 32'h0);
    send(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1, 2'd3, 32'h0);
    drain();
    chk("err_count_t4", 64'(err_count), 3);
    chk("addr_hold_t4", 64'(out_addr), 64'(exp_addr));
    chk("err_code_sticky", 64'(err_code), 3);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1048577, 1, 2'd2, 32'h0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1, 1, 2'd3, 32'h0);
    send(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd2049, 1, 2'd1, 32'h0);
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096, 1, 2'd1, 32'h0);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1048576, 1, 2'd1, 32'h0);
    // In-range boundaries through the model
    send(3'd0, 5'd7, 5'd8, 5'd0, 3'd2, 32'd2047, 0, 2'd0, 32'h0);
    send(3'd2, 5'd0, 5'd9, 5'd31, 3'd1, -32'sd2048, 0, 2'd0, 32'h0);
    send(3'd3, 5'd0, 5'd3, 5'd4, 3'd5, 32'd4094, 0, 2'd0, 32'h0);
    send(3'd3, 5'd0, 5'd3, 5'd4, 3'd5, -32'sd4096, 0, 2'd0, 32'h0);
    send(3'd4, 5'd31, 5'd0, 5'd0, 3'd0, 32'd1048574, 0, 2'd0, 32'h0);
    send(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, -32'sd1048576, 0, 2'd0, 32'h0);
    drain();
    chk("inst_count_t4", 64'(inst_count), 64'(exp_inst));
    chk("err_count_t4b", 64'(err_count), 64'(exp_errn));

    // Streaming under toggling out_ready from a fresh base
    do_reset();
    toggle_en = 1'b1;
    for (int k = 0; k < 4; k++)
      send(3'd1, 5'(k + 1), 5'd2, 5'd0, 3'd0, 32'(k * 16), 0, 2'd0, 32'h0);
    toggle_en = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("inst_count_t5", 64'(inst_count), 4);
    chk("next_addr_t5", 64'(out_addr), 64'(BASE + 32'h10));

    // Random traffic with random backpressure
    rand_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 8190)) - 4096);
        1: imm = 32'($signed($urandom_range(0, 2097150)) - 1048576);
        2: imm = $urandom();
        default: imm = 32'($urandom_range(0, 16)) << 1;
      endcase
      send(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), imm, 0, 2'd0, 32'h0);
    end
    rand_en = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("inst_count_rand", 64'(inst_count), 64'(exp_inst));
    chk("err_count_rand", 64'(err_count), 64'(exp_errn));
    chk("addr_rand", 64'(out_addr), 64'(exp_addr));

    // Reset while an output is stalled
    out_ready = 1'b0;
    send(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 32'd5, 0, 2'd0, 32'h0);
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); err_q.delete();
    exp_addr = BASE; exp_inst = 0; exp_errn = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_out_addr", 64'(out_addr), 64'(BASE));
    chk("mid_rst_inst_count", 64'(inst_count), 0);
    chk("mid_rst_err_count", 64'(err_count), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
